sd_cmd_sequencer: RTL

//  Hardware SD-over-SPI command sequencer sitting in front of the SPI shifter FIFO path.
//  On start it asserts slave select and shifts out the 6-byte command frame, then polls
//  for R1 and, if asked, waits for the start token and streams one data block to a sink.

---
 rtl/sd_seq_pkg.sv | 56 +++++
 rtl/sd_byte_xfer.sv | 66 ++++++
 rtl/sd_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_seq_pkg.sv
// Shared types and constants for the SD-over-SPI command sequencer.
package sd_seq_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_CMD,
    S_RESP,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_TAIL,
    S_FIN
  } seq_state_t;

  // Completion status codes reported on the status port
  typedef enum logic [2:0] {
    ST_OK            = 3'd0,
    ST_R1_TIMEOUT    = 3'd1,
    ST_TOKEN_TIMEOUT = 3'd2,
    ST_ERR_TOKEN     = 3'd3,
    ST_ABORTED       = 3'd4,
    ST_R1_ERR        = 3'd5
  } seq_status_t;

  // Phases of the single-byte lock-step transfer unit
  typedef enum logic [1:0] {
    X_IDLE,
    X_TX,
    X_RX
  } xfer_state_t;

  localparam logic [7:0] FILL_BYTE     = 8'hFF;
  localparam logic [7:0] TOKEN_START   = 8'hFE;
  localparam int         CMD_FRAME_LEN = 6;

  // Byte n of the 6-byte command frame: start/tx bits + index, argument MSB first, CRC7 + end bit.
  function automatic logic [7:0] frame_byte(input logic [5:0]  idx,
                                            input logic [31:0] arg,
                                            input logic [6:0]  crc,
                                            input logic [2:0]  n);
    logic [7:0] b;
    case (n)
      3'd0:    b = {2'b01, idx};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      3'd5:    b = {crc, 1'b1};
      default: b = FILL_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_byte_xfer.sv
// One-byte lock-step transfer: push a byte to the tx FIFO, then wait for exactly one rx byte.
module sd_byte_xfer
  import sd_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] byte_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       rx_accept,
  output logic       rx_wait,
  output logic [7:0] byte_out,
  output logic       byte_done,
  output logic       pending
);

  xfer_state_t state_q, state_d;
  logic [7:0]  data_q, data_d;

  // Phase register and held tx byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= X_IDLE;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next phase: go only starts a transfer when idle; tx byte stays stable until accepted
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      X_IDLE: begin
        if (go) begin
          data_d  = byte_in;
          state_d = X_TX;
        end
      end
      X_TX: begin
        if (tx_ready) state_d = X_RX;
      end
      X_RX: begin
        if (rx_valid && rx_accept) state_d = X_IDLE;
      end
      default: state_d = X_IDLE;
    endcase
  end

  // rx_accept lets the owner stall the rx side (sink backpressure)
  assign tx_valid  = (state_q == X_TX);
  assign tx_data   = data_q;
  assign rx_wait   = (state_q == X_RX);
  assign rx_ready  = rx_wait & rx_accept;
  assign byte_done = rx_wait & rx_valid & rx_accept;
  assign byte_out  = rx_data;
  assign pending   = (state_q != X_IDLE);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD-over-SPI command sequencer: sends a command frame, polls R1, optionally streams one data block.
module sd_cmd_sequencer
  import sd_seq_pkg::*;
#(
  parameter int NCR_MAX   = 8,
  parameter int TOKEN_MAX = 4096,
  parameter int BLOCK_LEN = 512
) (
  input  logic        C100M,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        read_block,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [7:0]  r1,
  output logic        ss,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  blk_data,
  output logic        blk_valid,
  input  logic        blk_ready
);

  localparam int BCW = $clog2(BLOCK_LEN + 1);

  seq_state_t  state_q, state_d;
  seq_status_t status_q, status_d;
  logic        busy_q, busy_d;
  logic        ss_q, ss_d;
  logic [7:0]  r1_q, r1_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic        rb_q, rb_d;
  logic [15:0] poll_q, poll_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic        abort_pend_q, abort_pend_d;

  logic        go;
  logic [7:0]  byte_in;
  logic        rx_accept;
  logic        rx_wait;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        pending;
  logic        aborting;
  logic        abortable;
  logic [15:0] poll_inc;

  sd_byte_xfer u_xfer (
    .clk       (C100M),
    .rst       (reset),
    .go        (go),
    .byte_in   (byte_in),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_accept (rx_accept),
    .rx_wait   (rx_wait),
    .byte_out  (rx_byte),
    .byte_done (byte_done),
    .pending   (pending)
  );

  // An abort seen once stays pending until the in-flight byte has been drained
  assign aborting  = abort | abort_pend_q;
  assign abortable = (state_q == S_SEL)   || (state_q == S_CMD)  || (state_q == S_RESP) ||
                     (state_q == S_TOKEN) || (state_q == S_DATA) || (state_q == S_CRC);
  assign poll_inc  = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;

  // In DATA the sink throttles the rx side, except when draining after abort (byte is discarded)
  assign rx_accept = (state_q != S_DATA) | aborting | blk_ready;
  assign blk_valid = (state_q == S_DATA) & rx_wait & rx_valid & ~aborting;
  assign blk_data  = (state_q == S_DATA) ? rx_data : 8'h00;

  assign busy   = busy_q;
  assign done   = (state_q == S_FIN);
  assign status = status_q;
  assign r1     = r1_q;
  assign ss     = ss_q;

  // State, captured command and counters
  always_ff @(posedge C100M or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      status_q     <= ST_OK;
      busy_q       <= 1'b0;
      ss_q         <= 1'b0;
      r1_q         <= 8'hFF;
      idx_q        <= 6'd0;
      arg_q        <= 32'd0;
      crc_q        <= 7'd0;
      rb_q         <= 1'b0;
      poll_q       <= 16'd0;
      bcnt_q       <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      busy_q       <= busy_d;
      ss_q         <= ss_d;
      r1_q         <= r1_d;
      idx_q        <= idx_d;
      arg_q        <= arg_d;
      crc_q        <= crc_d;
      rb_q         <= rb_d;
      poll_q       <= poll_d;
      bcnt_q       <= bcnt_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Sequencer next state: issue one byte at a time whenever the transfer unit is idle
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    busy_d       = busy_q;
    ss_d         = ss_q;
    r1_d         = r1_q;
    idx_d        = idx_q;
    arg_d        = arg_q;
    crc_d        = crc_q;
    rb_d         = rb_q;
    poll_d       = poll_q;
    bcnt_d       = bcnt_q;
    abort_pend_d = abort_pend_q;
    go           = 1'b0;
    byte_in      = FILL_BYTE;

    case (state_q)
      S_IDLE: begin
        // abort is deliberately not looked at here: a same-cycle start wins
        if (start) begin
          idx_d        = cmd_index;
          arg_d        = cmd_arg;
          crc_d        = cmd_crc;
          rb_d         = read_block;
          busy_d       = 1'b1;
          ss_d         = 1'b1;
          status_d     = ST_OK;
          r1_d         = FILL_BYTE;
          abort_pend_d = 1'b0;
          state_d      = S_SEL;
        end
      end
      S_SEL: begin
        state_d = S_CMD;
      end
      S_CMD: begin
        byte_in = frame_byte(idx_q, arg_q, crc_q, bcnt_q[2:0]);
        go      = ~pending;
        if (byte_done) begin
          if (int'(bcnt_q) == CMD_FRAME_LEN - 1) state_d = S_RESP;
          else                                   bcnt_d  = bcnt_q + BCW'(1);
        end
      end
      S_RESP: begin
        go = ~pending;
        if (byte_done) begin
          poll_d = poll_inc;
          if (!rx_byte[7]) begin
            r1_d = rx_byte;
            if (!rb_q) begin
              state_d  = S_TAIL;
              status_d = ST_OK;
            end else if (rx_byte != 8'h00) begin
              state_d  = S_TAIL;
              status_d = ST_R1_ERR;
            end else begin
              state_d  = S_TOKEN;
            end
          end else if (int'(poll_inc) >= NCR_MAX) begin
            state_d  = S_TAIL;
            status_d = ST_R1_TIMEOUT;
          end
        end
      end
      S_TOKEN: begin
        go = ~pending;
        if (byte_done) begin
          poll_d = poll_inc;
          if (rx_byte == TOKEN_START) begin
            state_d = S_DATA;
          end else if (rx_byte[7:4] == 4'h0 && rx_byte != 8'h00) begin
            state_d  = S_TAIL;
            status_d = ST_ERR_TOKEN;
          end else if (int'(poll_inc) >= TOKEN_MAX) begin
            state_d  = S_TAIL;
            status_d = ST_TOKEN_TIMEOUT;
          end
        end
      end
      S_DATA: begin
        go = ~pending;
        if (byte_done) begin
          if (int'(bcnt_q) == BLOCK_LEN - 1) state_d = S_CRC;
          else                               bcnt_d  = bcnt_q + BCW'(1);
        end
      end
      S_CRC: begin
        go = ~pending;
        if (byte_done) begin
          if (int'(bcnt_q) == 1) state_d = S_TAIL;
          else                   bcnt_d  = bcnt_q + BCW'(1);
        end
      end
      S_TAIL: begin
        go = ~pending;
        if (byte_done) begin
          ss_d    = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any match this cycle: stop issuing, drain the in-flight byte, then tail out
    if (abortable && aborting) begin
      go = 1'b0;
      if (!pending || byte_done) begin
        state_d      = S_TAIL;
        status_d     = ST_ABORTED;
        abort_pend_d = 1'b0;
      end else begin
        state_d      = state_q;
        abort_pend_d = 1'b1;
      end
    end

    // Counters restart on every state change
    if (state_d != state_q) begin
      bcnt_d = '0;
      poll_d = 16'd0;
    end
  end

endmodule
